// File: rtl/dts_pkg.sv
// Shared DTS constants: problem dimensions, worker count and result geometry used by the
// result arbiter, the pick helper and the worker array.
package dts_pkg;

  localparam int unsigned DTS_N           = 14;
  localparam int unsigned DTS_M           = 140;
  localparam int unsigned DTS_NUM_WORKERS = 8;
  localparam int unsigned DTS_RES_W       = DTS_N * (DTS_M + 1);
  localparam int unsigned DTS_IDX_W       = $clog2(DTS_NUM_WORKERS);
  localparam int unsigned DTS_DEPTH       = 4;
  localparam int unsigned DTS_ENTRY_W     = DTS_IDX_W + DTS_RES_W;

endpackage

// File: rtl/dts_rr_pick.sv
// Combinational round-robin pick: first set request bit at or above ptr_i, wrapping to 0.
module dts_rr_pick #(
  parameter int unsigned N    = 8,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic            gnt_valid_o,
  output logic [IdxW-1:0] gnt_idx_o
);

  int unsigned     sum;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    sum         = 0;
    cand        = '0;
    // Walk offsets from farthest to nearest so the nearest requester wins last.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      sum  = int'(ptr_i) + i;
      cand = IdxW'(sum % N);
      if (req_i[cand]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/dts_result_arbiter.sv
// Round-robin collector for DTS workers: captures finished results into a small FIFO,
// streams them out on valid/ready and issues per-worker restart pulses.
module dts_result_arbiter
  import dts_pkg::*;
#(
  parameter int unsigned NUM_WORKERS = DTS_NUM_WORKERS,
  parameter int unsigned RES_W       = DTS_RES_W,
  parameter int unsigned DEPTH       = DTS_DEPTH,
  parameter int unsigned IDX_W       = $clog2(NUM_WORKERS)
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_WORKERS-1:0]       worker_done,
  input  logic [NUM_WORKERS*RES_W-1:0] worker_result,
  output logic [NUM_WORKERS-1:0]       worker_next,
  input  logic                         auto_next,
  input  logic                         next_req,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [RES_W-1:0]             out_data,
  output logic [IDX_W-1:0]             out_worker,
  output logic [IDX_W:0]               fifo_level,
  output logic [15:0]                  result_count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned ENTRY_W = IDX_W + RES_W;

  logic [NUM_WORKERS-1:0] held_q, held_d;
  logic [NUM_WORKERS-1:0] next_q, next_d;
  logic [NUM_WORKERS-1:0] elig, gnt_oh;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic                   push, pop, full;
  logic [PTR_W:0]         wr_q, wr_d, rd_q, rd_d, level;
  logic [15:0]            cnt_q, cnt_d;
  logic [ENTRY_W-1:0]     mem_q [DEPTH];
  logic [ENTRY_W-1:0]     push_entry, head;

  assign elig = worker_done & ~held_q;

  dts_rr_pick #(
    .N   (NUM_WORKERS),
    .IdxW(IDX_W)
  ) u_pick (
    .req_i      (elig),
    .ptr_i      (ptr_q),
    .gnt_valid_o(pick_valid),
    .gnt_idx_o  (pick_idx)
  );

  always_comb begin
    level     = wr_q - rd_q;
    full      = (level == (PTR_W + 1)'(DEPTH));
    // Grant only against the registered level; a same-cycle pop gives no credit.
    push      = pick_valid & ~full;
    out_valid = (level != '0);
    pop       = out_valid & out_ready;

    gnt_oh = '0;
    if (push) gnt_oh[pick_idx] = 1'b1;
    push_entry = {pick_idx, worker_result[int'(pick_idx) * RES_W +: RES_W]};

    // Held bits drop as soon as the worker's done is seen low.
    held_d = (held_q | gnt_oh) & worker_done;
    next_d = (auto_next ? gnt_oh : '0) | (next_req ? (held_q & worker_done) : '0);

    ptr_d = ptr_q;
    if (push) ptr_d = (pick_idx == IDX_W'(NUM_WORKERS - 1)) ? '0 : pick_idx + 1'b1;

    wr_d  = wr_q + (PTR_W + 1)'(push);
    rd_d  = rd_q + (PTR_W + 1)'(pop);
    cnt_d = cnt_q + 16'(push);

    head         = mem_q[rd_q[PTR_W-1:0]];
    out_worker   = out_valid ? head[ENTRY_W-1 -: IDX_W] : '0;
    out_data     = out_valid ? head[RES_W-1:0] : '0;
    fifo_level   = (IDX_W + 1)'(level);
    worker_next  = next_q;
    result_count = cnt_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      held_q <= '0;
      next_q <= '0;
      ptr_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      held_q <= held_d;
      next_q <= next_d;
      ptr_q  <= ptr_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      if (push) mem_q[wr_q[PTR_W-1:0]] <= push_entry;
    end
  end

endmodule

// File: tb/tb_dts_result_arbiter.sv
// Directed bench for dts_result_arbiter: expected stream entries are queued at stimulus time
// and a negedge monitor pops and compares on every handshake.
module tb_dts_result_arbiter;

  localparam int NW = 8;
  localparam int RW = 1974;
  localparam int IW = 3;

  typedef struct packed {
    logic [IW-1:0] w;
    logic [RW-1:0] d;
  } exp_t;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [NW-1:0]    done = '0;
  logic [RW-1:0]    res_arr [NW];
  logic [NW*RW-1:0] worker_result;
  logic [NW-1:0]    worker_next;
  logic             auto_next = 1'b0;
  logic             next_req = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [RW-1:0]    out_data;
  logic [IW-1:0]    out_worker;
  logic [IW:0]      fifo_level;
  logic [15:0]      result_count;

  exp_t exp_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  logic          stall_v = 1'b0;
  logic [IW-1:0] stall_w;
  logic [RW-1:0] stall_d;

  always #5 clk = ~clk;

  always_comb begin
    worker_result = '0;
    for (int u = 0; u < NW; u++) worker_result[u*RW +: RW] = res_arr[u];
  end

  dts_result_arbiter dut (
    .clk          (clk),
    .resetn       (resetn),
    .worker_done  (done),
    .worker_result(worker_result),
    .worker_next  (worker_next),
    .auto_next    (auto_next),
    .next_req     (next_req),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_worker   (out_worker),
    .fifo_level   (fifo_level),
    .result_count (result_count)
  );

  function automatic logic [RW-1:0] mk_res(int u, int gen);
    logic [RW-1:0] r;
    for (int b = 0; b < RW; b++) r[b] = (((b + 3 * u + 7 * gen) % 5) == 0);
    r[15:0] = 16'hA000 | 16'(u << 4) | 16'(gen);
    return r;
  endfunction

  task automatic push_exp(int u);
    exp_t e;
    e.w = IW'(u);
    e.d = res_arr[u];
    exp_q.push_back(e);
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    vec_cnt++;
    if (act !== expv) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream monitor: hold-while-stalled check plus scoreboard pop on every handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      stall_v = 1'b0;
    end else begin
      if (stall_v) begin
        vec_cnt++;
        if (!out_valid || out_worker !== stall_w || out_data !== stall_d) begin
          err_cnt++;
          $display("FAIL stall_hold: got valid=%0b worker=%0d expected valid=1 worker=%0d",
                   out_valid, out_worker, stall_w);
        end
      end
      stall_v = out_valid && !out_ready;
      stall_w = out_worker;
      stall_d = out_data;
      if (out_valid && out_ready) begin
        vec_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL stream_extra: got worker %0d expected no output", out_worker);
        end else begin
          e = exp_q.pop_front();
          if (out_worker !== e.w || out_data !== e.d) begin
            err_cnt++;
            $display("FAIL stream: got worker %0d tag %h expected worker %0d tag %h",
                     out_worker, out_data[15:0], e.w, e.d[15:0]);
          end
        end
      end
    end
  end

  initial begin
    for (int u = 0; u < NW; u++) res_arr[u] = mk_res(u, 0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", {31'b0, out_valid}, 0);
    check("rst_next", {24'b0, worker_next}, 0);
    check("rst_level", {28'b0, fifo_level}, 0);
    check("rst_count", {16'b0, result_count}, 0);
    check("rst_worker", {29'b0, out_worker}, 0);
    check("rst_data", {31'b0, |out_data}, 0);
    step();
    resetn = 1'b1;
    step();

    // Single worker, auto restart
    auto_next = 1'b1;
    out_ready = 1'b1;
    done[5] = 1'b1;
    push_exp(5);
    @(negedge clk);
    check("single_pre_valid", {31'b0, out_valid}, 0);
    check("single_pre_next", {24'b0, worker_next}, 0);
    step();
    @(negedge clk);
    check("single_valid", {31'b0, out_valid}, 1);
    check("single_worker", {29'b0, out_worker}, 5);
    check("single_next", {24'b0, worker_next}, 32'h20);
    check("single_count", {16'b0, result_count}, 1);
    step();
    @(negedge clk);
    check("single_next_oneshot", {24'b0, worker_next}, 0);
    step();
    done = '0;
    step();
    step();
    @(negedge clk);
    check("single_count_after", {16'b0, result_count}, 1);

    // Fairness from ptr=0, manual restart
    step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    step();
    auto_next = 1'b0;
    done = 8'hFF;
    for (int u = 0; u < NW; u++) push_exp(u);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("fair_no_next", {24'b0, worker_next}, 0);
      step();
    end
    @(negedge clk);
    check("fair_count", {16'b0, result_count}, 8);
    check("fair_level", {28'b0, fifo_level}, 0);
    step();
    next_req = 1'b1;
    step();
    next_req = 1'b0;
    @(negedge clk);
    check("fair_next_all", {24'b0, worker_next}, 32'hFF);
    step();
    @(negedge clk);
    check("fair_next_oneshot", {24'b0, worker_next}, 0);
    step();
    done = '0;
    step();
    step();

    // Backpressure: FIFO fills with 0..3, 4 and 5 wait
    auto_next = 1'b1;
    out_ready = 1'b0;
    done = 8'h3F;
    for (int u = 0; u < 6; u++) push_exp(u);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("bp_waiting_no_next", {24'b0, worker_next & 8'h30}, 0);
      step();
    end
    @(negedge clk);
    check("bp_level_full", {28'b0, fifo_level}, 4);
    check("bp_count", {16'b0, result_count}, 12);
    check("bp_head", {29'b0, out_worker}, 0);
    step();
    out_ready = 1'b1;
    repeat (10) step();
    @(negedge clk);
    check("bp_count_drained", {16'b0, result_count}, 14);
    check("bp_level_empty", {28'b0, fifo_level}, 0);
    step();
    done = '0;
    step();
    step();

    // Simultaneous push and pop at level 2 (ptr is 6 here)
    out_ready = 1'b0;
    done = 8'h03;
    push_exp(0);
    push_exp(1);
    step();
    step();
    @(negedge clk);
    check("pp_level_before", {28'b0, fifo_level}, 2);
    step();
    done = 8'h07;
    out_ready = 1'b1;
    push_exp(2);
    step();
    out_ready = 1'b0;
    @(negedge clk);
    check("pp_level_after", {28'b0, fifo_level}, 2);
    check("pp_head", {29'b0, out_worker}, 1);
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge clk);
      check("pp_level_hold", {28'b0, fifo_level}, 2);
    end
    step();
    out_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("pp_level_drained", {28'b0, fifo_level}, 0);
    step();
    done = '0;
    step();
    step();

    // Mid-stream reset with three entries buffered (those entries are discarded)
    out_ready = 1'b0;
    done = 8'h07;
    repeat (3) step();
    @(negedge clk);
    check("mid_level_3", {28'b0, fifo_level}, 3);
    step();
    resetn = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, out_valid}, 0);
    check("mid_rst_level", {28'b0, fifo_level}, 0);
    check("mid_rst_next", {24'b0, worker_next}, 0);
    check("mid_rst_count", {16'b0, result_count}, 0);
    done = '0;
    step();
    resetn = 1'b1;
    step();
    @(negedge clk);
    check("mid_no_stale_valid", {31'b0, out_valid}, 0);
    step();

    // Lingering done is not re-captured; a fresh rise is
    out_ready = 1'b1;
    done[2] = 1'b1;
    push_exp(2);
    step();
    @(negedge clk);
    check("ling_next", {24'b0, worker_next}, 32'h04);
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge clk);
      check("ling_no_next", {24'b0, worker_next}, 0);
      check("ling_count_1", {16'b0, result_count}, 1);
    end
    step();
    done[2] = 1'b0;
    step();
    res_arr[2] = mk_res(2, 1);
    done[2] = 1'b1;
    push_exp(2);
    step();
    @(negedge clk);
    check("ling_next_again", {24'b0, worker_next}, 32'h04);
    check("ling_count_2", {16'b0, result_count}, 2);
    step();
    done = '0;
    repeat (3) step();

    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
